// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset (R/ADDI/LW/SW/BEQ/BNE/J) with one shared ALU and req/ack instruction/data ports.
// Latency J 2, BEQ/BNE 3, R/ADDI/SW 4, LW 5 cycles plus one per memory wait cycle; req held until ack.
// `ILLEGAL_TRAP_EN: undefined opcodes halt the core (exit via rst_n) instead of retiring as NOPs.
module mips_multicycle_core #(
  parameter int              PC_W     = 8,
  parameter int              DMEM_AW  = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ack,
  input  logic [31:0]        dmem_rdata,
  output logic [PC_W-1:0]    pc_out,
  output logic               retire,
  output logic               halted
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     alu_q, alu_d;
  logic [31:0]     mdr_q, mdr_d;
  logic            imem_req_q, dmem_req_q;
  logic [31:0]     rf_q [32];

  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic        is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_legal;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  assign is_r     = (opcode == OP_R);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_j     = (opcode == OP_J);
  assign is_legal = is_r | is_addi | is_lw | is_sw | is_beq | is_bne | is_j;

  // Shared ALU: R-type ops, address/immediate add, and the branch compare all go through here.
  logic [31:0] alu_y;
  logic        alu_zero, br_taken;
  logic [PC_W-1:0] pc_branch;

  always_comb begin
    alu_y = a_q + imm_sext;
    if (is_r) begin
      case (funct)
        F_ADD:   alu_y = a_q + b_q;
        F_SUB:   alu_y = a_q - b_q;
        F_AND:   alu_y = a_q & b_q;
        F_OR:    alu_y = a_q | b_q;
        F_SLT:   alu_y = {31'd0, $signed(a_q) < $signed(b_q)};
        default: alu_y = '0;
      endcase
    end else if (is_beq || is_bne) begin
      alu_y = a_q - b_q;
    end
  end

  assign alu_zero  = (alu_y == '0);
  assign br_taken  = (is_beq && alu_zero) || (is_bne && !alu_zero);
  assign pc_branch = pc_q + imm_sext[PC_W-1:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = alu_q;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rf_q[rs];
        b_d = rf_q[rt];
        if (is_j) begin
          pc_d    = ir_q[PC_W-1:0];
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (!is_legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          retire  = 1'b1;
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d = alu_y;
        if (is_beq || is_bne) begin
          if (br_taken) pc_d = pc_branch;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ack) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        if (is_lw) begin
          rf_waddr = rt;
          rf_wdata = mdr_q;
        end else if (!is_r) begin
          rf_waddr = rt;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Requests are registered so that an asynchronous reset drops them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      mdr_q      <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_q      <= alu_d;
      mdr_q      <= mdr_d;
      imem_req_q <= (state_d == S_FETCH);
      dmem_req_q <= (state_d == S_MEM);
    end
  end

  // r0 is never written, so it always reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_req_q & is_sw;
  assign dmem_addr  = alu_q[DMEM_AW-1:0];
  assign dmem_wdata = b_q;
  assign pc_out     = pc_q;

`ifdef ILLEGAL_TRAP_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
